// File: rtl/seq_div_nonrestoring.sv
// Sequential unsigned divider using the non-restoring algorithm.
// One add/subtract of the divisor per iteration, followed by a single
// correction step, wrapped in a valid/ready handshake on both sides.
module seq_div_nonrestoring #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Partial remainder carries a sign bit plus one guard bit so that
    // the shifted value (range [-2D, 2D)) never overflows.
    localparam int RW = WIDTH + 2;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [WIDTH-1:0]       q_reg, q_next;
    logic [WIDTH-1:0]       d_reg, d_next;
    logic signed [RW-1:0]   r_reg, r_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [WIDTH-1:0]       quotient_reg, quotient_next;
    logic [WIDTH-1:0]       remainder_reg, remainder_next;
    logic                   dbz_reg, dbz_next;

    // Shared datapath: shifted remainder, one add/sub step, final correction
    logic signed [RW-1:0]   d_ext;
    logic signed [RW-1:0]   r_shift;
    logic signed [RW-1:0]   r_step;
    logic signed [RW-1:0]   r_fix;

    assign d_ext   = $signed({2'b00, d_reg});
    assign r_shift = {r_reg[RW-2:0], q_reg[WIDTH-1]};
    // Previous remainder sign picks add or subtract: the non-restoring rule
    assign r_step  = r_reg[RW-1] ? (r_shift + d_ext) : (r_shift - d_ext);
    // A negative final remainder is restored once by adding the divisor back
    assign r_fix   = r_reg[RW-1] ? (r_reg + d_ext) : r_reg;

    // in_ready is forced low while reset is asserted
    assign in_ready    = rst_n && (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_next     = state_reg;
        q_next         = q_reg;
        d_next         = d_reg;
        r_next         = r_reg;
        cnt_next       = cnt_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    d_next = divisor;
                    if (divisor != '0) begin
                        q_next     = dividend;
                        r_next     = '0;
                        cnt_next   = '0;
                        state_next = CALC;
                    end else begin
                        // Divide by zero short-circuits straight to the result
                        quotient_next  = '1;
                        remainder_next = dividend;
                        dbz_next       = 1'b1;
                        state_next     = DONE;
                    end
                end
            end
            CALC: begin
                r_next   = r_step;
                q_next   = {q_reg[WIDTH-2:0], ~r_step[RW-1]};
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_ITER) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                r_next         = r_fix;
                quotient_next  = q_reg;
                remainder_next = r_fix[WIDTH-1:0];
                dbz_next       = 1'b0;
                state_next     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and result registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg         <= '0;
            d_reg         <= '0;
            r_reg         <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            q_reg         <= q_next;
            d_reg         <= d_next;
            r_reg         <= r_next;
            cnt_reg       <= cnt_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

endmodule

// File: tb/tb_seq_div_nonrestoring.sv
// Testbench for seq_div_nonrestoring: directed table, handshake corner
// cases, exhaustive 4-bit sweep and random 8-bit operations.
module tb_seq_div_nonrestoring;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, div_by_zero;
    logic [3:0] dividend, divisor, quotient, remainder;

    logic       v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready, v8_div_by_zero;
    logic [7:0] v8_dividend, v8_divisor, v8_quotient, v8_remainder;

    seq_div_nonrestoring #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    seq_div_nonrestoring #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8_in_valid), .in_ready(v8_in_ready),
        .dividend(v8_dividend), .divisor(v8_divisor),
        .out_valid(v8_out_valid), .out_ready(v8_out_ready),
        .quotient(v8_quotient), .remainder(v8_remainder),
        .div_by_zero(v8_div_by_zero)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    // One WIDTH=4 operation; lat = edges after the accept edge until out_valid
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit rnd,
                       output logic [3:0] q, output logic [3:0] r,
                       output logic z, output int lat);
        int  n;
        bit  done;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("accept_wait", 32'(n < 200), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        n = 0;
        do begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            done = out_ready;
            @(posedge clk); #1; n++;
            if (!done) begin
                check("hold_q", 32'(quotient), 32'(q));
                check("hold_r", 32'(remainder), 32'(r));
            end
        end while (!done && n < 200);
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        $display("op4 %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", a, b, q, r, z, lat);
    endtask

    // One WIDTH=8 operation with random output backpressure
    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        int  n;
        bit  done;
        logic [7:0] eq, er;
        logic       ez;
        v8_dividend  = a;
        v8_divisor   = b;
        v8_in_valid  = 1'b1;
        v8_out_ready = 1'b0;
        n = 0;
        while (!v8_in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        v8_in_valid = 1'b0;
        n = 0;
        while (!v8_out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("w8_latency", 32'(n), (b == 0) ? 32'd0 : 32'd9);
        if (b == 0) begin
            eq = 8'hFF; er = a; ez = 1'b1;
        end else begin
            eq = a / b; er = a % b; ez = 1'b0;
        end
        check("w8_q", 32'(v8_quotient), 32'(eq));
        check("w8_r", 32'(v8_remainder), 32'(er));
        check("w8_dbz", 32'(v8_div_by_zero), 32'(ez));
        $display("op8 %0d/%0d -> q=%0d r=%0d dbz=%0d", a, b, v8_quotient, v8_remainder, v8_div_by_zero);
        n = 0;
        do begin
            v8_out_ready = 1'($urandom_range(0, 1));
            done = v8_out_ready;
            @(posedge clk); #1; n++;
        end while (!done && n < 200);
        v8_out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] q, r;
        logic       z;
        int         lat;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        v8_in_valid = 1'b0; v8_out_ready = 1'b0; v8_dividend = '0; v8_divisor = '0;

        vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 5};
        vecs[1] = '{4'd7,  4'd9,  4'd0,  4'd7, 1'b0, 5};
        vecs[2] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5};
        vecs[3] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5};
        vecs[4] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 5};
        vecs[5] = '{4'd9,  4'd0,  4'd15, 4'd9, 1'b1, 0};
        vecs[6] = '{4'd1,  4'd0,  4'd15, 4'd1, 1'b1, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            op4(vecs[i].a, vecs[i].b, 1'b0, q, r, z, lat);
            check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].q));
            check($sformatf("vec%0d_r", i), 32'(r), 32'(vecs[i].r));
            check($sformatf("vec%0d_dbz", i), 32'(z), 32'(vecs[i].z));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure with stray in_valid during CALC and DONE
        dividend = 4'd14; divisor = 4'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        dividend = 4'd5; divisor = 4'd1;
        check("bp_busy_in_ready", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            in_valid = ~in_valid;
            @(posedge clk); #1; lat++;
        end
        check("bp_lat", 32'(lat), 32'd5);
        for (int k = 0; k < 6; k++) begin
            in_valid = ~in_valid;
            @(posedge clk); #1;
            check("bp_hold_q", 32'(quotient), 32'd3);
            check("bp_hold_r", 32'(remainder), 32'd2);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        check("bp_keep_q", 32'(quotient), 32'd3);
        @(posedge clk); #1;
        check("bp_no_stray_op", 32'(in_ready), 32'd1);
        $display("backpressure 14/4 -> q=%0d r=%0d", quotient, remainder);

        // Reset during CALC cycle 2
        dividend = 4'd13; divisor = 4'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_rel_ready", 32'(in_ready), 32'd1);
        op4(4'd11, 4'd2, 1'b0, q, r, z, lat);
        check("post_abort_q", 32'(q), 32'd5);
        check("post_abort_r", 32'(r), 32'd1);
        check("post_abort_dbz", 32'(z), 32'd0);

        // Exhaustive 4-bit sweep with random out_ready
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op4(4'(a), 4'(b), 1'b1, q, r, z, lat);
                if (b == 0) begin
                    check("exh_q", 32'(q), 32'd15);
                    check("exh_r", 32'(r), 32'(a));
                    check("exh_dbz", 32'(z), 32'd1);
                    check("exh_lat", 32'(lat), 32'd0);
                end else begin
                    check("exh_q", 32'(q), 32'(a / b));
                    check("exh_r", 32'(r), 32'(a % b));
                    check("exh_dbz", 32'(z), 32'd0);
                    check("exh_lat", 32'(lat), 32'd5);
                end
            end
        end

        // Random 8-bit operations
        for (int i = 0; i < 2000; i++) begin
            op8(8'($urandom_range(0, 255)), (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
